// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle ripple adder that iterates a DIGIT-bit slice
// over WIDTH/DIGIT cycles, with a start/busy/done handshake and carry/overflow flags.
module serial_adder_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               last;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_q;
  logic               carry_q;
  logic [CW-1:0]      cnt_q;

  logic [DIGIT-1:0]   a_dig;
  logic [DIGIT-1:0]   b_dig;
  logic [DIGIT:0]     dig_sum;
  logic [WIDTH-1:0]   acc_nxt;
  logic               ovf_nxt;

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt_q == CW'(NDIG - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit slice: select the current digit, add with the carry, and merge the
  // result into a copy of the partial sum so the final digit is visible at once.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
    dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    acc_nxt = acc_q;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (cnt_q == CW'(i)) acc_nxt[i*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
    end
    ovf_nxt = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
  end

  // State register plus registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand capture, digit iteration and result update on the completion edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      acc_q   <= acc_nxt;
      carry_q <= dig_sum[DIGIT];
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      if (last) begin
        sum <= acc_nxt;
        co  <= dig_sum[DIGIT];
        ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: three parametrisations (8/2, 16/1, 8/8) checked
// against a table of known sums and an arithmetic reference model.
module tb_serial_adder_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start0, cin0, busy0, done0, co0, ovf0;
  logic [7:0]  a0, b0, sum0;
  logic        start1, cin1, busy1, done1, co1, ovf1;
  logic [15:0] a1, b1, sum1;
  logic        start2, cin2, busy2, done2, co2, ovf2;
  logic [7:0]  a2, b2, sum2;

  serial_adder_n #(.WIDTH(8), .DIGIT(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .busy(busy0), .done(done0), .sum(sum0), .co(co0), .ovf(ovf0));
  serial_adder_n #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1));
  serial_adder_n #(.WIDTH(8), .DIGIT(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .co(co2), .ovf(ovf2));

  int          sel;
  logic        m_busy, m_done, m_co, m_ovf;
  logic [15:0] m_sum;
  logic [15:0] prev [3];
  int          nvec  = 0;
  int          nfail = 0;

  // Route the selected instance's outputs to one set of observation signals.
  always_comb begin
    m_busy = busy0; m_done = done0; m_sum = {8'h00, sum0}; m_co = co0; m_ovf = ovf0;
    case (sel)
      1: begin m_busy = busy1; m_done = done1; m_sum = sum1; m_co = co1; m_ovf = ovf1; end
      2: begin m_busy = busy2; m_done = done2; m_sum = {8'h00, sum2}; m_co = co2; m_ovf = ovf2; end
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input int s, input logic st, input logic [15:0] aa,
                        input logic [15:0] bb, input logic cc);
    case (s)
      0: begin start0 = st; a0 = aa[7:0]; b0 = bb[7:0]; cin0 = cc; end
      1: begin start1 = st; a1 = aa;      b1 = bb;      cin1 = cc; end
      2: begin start2 = st; a2 = aa[7:0]; b2 = bb[7:0]; cin2 = cc; end
      default: ;
    endcase
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void ref_add(input int w, input longint aa, input longint bb,
                                  input int cc, output longint s, output bit c,
                                  output bit v);
    longint t, m, sa, sb, st;
    m  = longint'(1) << w;
    t  = aa + bb + longint'(cc);
    s  = t % m;
    c  = (t >= m);
    sa = (aa >= m / 2) ? aa - m : aa;
    sb = (bb >= m / 2) ? bb - m : bb;
    st = sa + sb + longint'(cc);
    v  = (st >= m / 2) || (st < -(m / 2));
  endfunction

  // Called at the negedge where start was just raised; returns edges from accept
  // (inclusive) to the first cycle with done, or 0 on timeout.
  task automatic wait_done(input int s, input logic [15:0] hold, input bit poke,
                           output int edges);
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_done) begin
        edges = i;
        break;
      end
      chk("busy_run", longint'(m_busy), 1);
      chk("sum_hold", longint'(m_sum), longint'(hold));
      if (i == 1) set_in(s, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      if (poke && i == 2) set_in(s, 1'b1, 16'h00AA, 16'($urandom), 1'b0);
      if (poke && i == 3) set_in(s, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
    end
    if (edges == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int s, input int ndig, input logic [15:0] aa,
                        input logic [15:0] bb, input logic cc, input logic [15:0] es,
                        input logic eco, input logic eovf, input bit poke);
    int edges;
    sel = s;
    @(negedge clk);
    set_in(s, 1'b1, aa, bb, cc);
    wait_done(s, prev[s], poke, edges);
    if (edges != 0) begin
      chk("latency", longint'(edges), longint'(ndig + 1));
      chk("sum", longint'(m_sum), longint'(es));
      chk("co", longint'(m_co), longint'(eco));
      chk("ovf", longint'(m_ovf), longint'(eovf));
      chk("busy_at_done", longint'(m_busy), 0);
      prev[s] = es;
      @(negedge clk);
      chk("done_pulse", longint'(m_done), 0);
      chk("sum_after", longint'(m_sum), longint'(es));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int     edges;
    longint rs, ra, rb;
    bit     rc, rv;
    int     rcin;

    tbl[0] = '{8'h03, 8'h01, 1'b0, 8'h04, 1'b0, 1'b0};
    tbl[1] = '{8'h0F, 8'h21, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[2] = '{8'h4F, 8'hE1, 1'b0, 8'h30, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    sel = 0;
    for (int k = 0; k < 3; k++) prev[k] = '0;
    reset = 1'b1;
    set_in(0, 1'b1, 16'h00FF, 16'h0001, 1'b1);
    set_in(1, 1'b0, 16'h0, 16'h0, 1'b0);
    set_in(2, 1'b0, 16'h0, 16'h0, 1'b0);

    // Reset held two cycles with start asserted: everything stays at reset values.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_busy", longint'(busy0), 0);
      chk("rst_done", longint'(done0), 0);
      chk("rst_sum", longint'(sum0), 0);
      chk("rst_co", longint'(co0), 0);
      chk("rst_ovf", longint'(ovf0), 0);
    end
    reset = 1'b0;
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);

    // Directed table; row 5 also pokes an ignored start mid-run.
    for (int k = 0; k < 6; k++)
      run_op(0, 4, {8'h00, tbl[k].a}, {8'h00, tbl[k].b}, tbl[k].cin,
             {8'h00, tbl[k].s}, tbl[k].co, tbl[k].ovf, k == 5);

    // Back-to-back: start held through the DONE cycle.
    sel = 0;
    @(negedge clk);
    set_in(0, 1'b1, 16'h0010, 16'h0020, 1'b0);
    wait_done(0, prev[0], 1'b0, edges);
    chk("b2b_first_sum", longint'(m_sum), 16'h30);
    prev[0] = 16'h0030;
    set_in(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    wait_done(0, 16'h0030, 1'b0, edges);
    chk("b2b_latency", longint'(edges), 5);
    chk("b2b_second_sum", longint'(m_sum), 16'h02);
    prev[0] = 16'h0002;
    @(negedge clk);
    chk("b2b_done_drop", longint'(m_done), 0);

    // Reset sampled at E2 aborts the run.
    @(negedge clk);
    set_in(0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) prev[k] = '0;
    chk("abort_busy", longint'(busy0), 0);
    chk("abort_done", longint'(done0), 0);
    chk("abort_sum", longint'(sum0), 0);
    chk("abort_co", longint'(co0), 0);
    chk("abort_ovf", longint'(ovf0), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", longint'(done0), 0);
    end
    run_op(0, 4, 16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b0);

    // Other parametrisations: bit-serial and single-cycle.
    run_op(1, 16, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(2, 1, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // Randomised operations against the reference model.
    for (int k = 0; k < 30; k++) begin
      ra = longint'($urandom_range(0, 255));
      rb = longint'($urandom_range(0, 255));
      rcin = int'($urandom_range(0, 1));
      ref_add(8, ra, rb, rcin, rs, rc, rv);
      run_op(0, 4, 16'(ra), 16'(rb), 1'(rcin), 16'(rs), rc, rv, 1'b0);
    end
    for (int k = 0; k < 10; k++) begin
      ra = longint'($urandom_range(0, 65535));
      rb = longint'($urandom_range(0, 65535));
      rcin = int'($urandom_range(0, 1));
      ref_add(16, ra, rb, rcin, rs, rc, rv);
      run_op(1, 16, 16'(ra), 16'(rb), 1'(rcin), 16'(rs), rc, rv, 1'b0);
    end
    for (int k = 0; k < 10; k++) begin
      ra = longint'($urandom_range(0, 255));
      rb = longint'($urandom_range(0, 255));
      rcin = int'($urandom_range(0, 1));
      ref_add(8, ra, rb, rcin, rs, rc, rv);
      run_op(2, 1, 16'(ra), 16'(rb), 1'(rcin), 16'(rs), rc, rv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised multi-cycle ripple adder: computes `a + b + cin` for a WIDTH-bit operand pair by iterating a DIGIT-bit adder slice over WIDTH/DIGIT clock cycles, carrying between digits through a register. It is the sequential, width-generic successor to the 8-bit combinational full adder. It trades latency for area and adds a start/done handshake plus a signed-overflow flag. It sits as a leaf datapath unit driven by a controller FSM.

## Interface

- `WIDTH`, default 8: operand and sum width. Must be a multiple of DIGIT.
- `DIGIT`, default 2: bits added per cycle, 1..WIDTH. NDIG = WIDTH/DIGIT.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request an operation; sampled only when `busy`=0.
- `a` input, WIDTH bits: operand A, captured when start is accepted.
- `b` input, WIDTH bits: operand B, captured when start is accepted.
- `cin` input, 1 bit: carry-in, captured when start is accepted.
- `busy` output, 1 bit: operation in progress.
- `done` output, 1 bit: one-cycle pulse; result valid.
- `sum` output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
- `co` output, 1 bit: unsigned carry out of the MSB.
- `ovf` output, 1 bit: two's-complement overflow.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 → latch a, b, cin into operand registers.
  - Clear the digit counter; load the carry register with cin.
  - Go to RUN.
- RUN, one digit per edge, LSB digit first (index = counter):
  - Compute {c, s} = a_dig + b_dig + carry, all DIGIT-bit wide plus carry.
  - Write s into the internal sum register at the digit position; carry ← c; counter++.
- Last digit (counter = NDIG-1):
  - Load the internal sum into the `sum` output.
  - `co` ← final carry.
  - `ovf` ← (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - Go to DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `start`=1 → accepted exactly as in IDLE; go to RUN (back-to-back operation).
  - Otherwise → IDLE.
- `start` while `busy`=1 is ignored; no queuing.
- Inputs a/b/cin may change freely after the accept edge without affecting the result.
- `sum`, `co` and `ovf` change only on the completion edge. They hold the previous result throughout RUN and afterwards until the next completion.
- Arithmetic is unsigned modular; `co` and `ovf` are both always computed. The caller chooses the signed or unsigned interpretation.
- DIGIT=WIDTH: a single RUN cycle. DIGIT=1: bit-serial operation.

## Timing

- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `co`=0, `ovf`=0, counter=0, carry=0.
- Accept edge E0 (state IDLE or DONE, `start`=1): `busy` rises after E0.
- Digits are processed on edges E1..E_NDIG.
- After E_NDIG: `busy`=0, `done`=1, result valid.
- After E_NDIG+1: `done`=0, unless a new accept occurred at E_NDIG+1, in which case `busy`=1 and `done`=0.
- Latency: NDIG+1 edges from accept to `done`. Throughput: one result per NDIG+1 cycles.
- `reset` overrides everything, including mid-RUN: the operation is aborted with no `done`, all outputs return to their reset values, and `start` is ignored on the reset edge.
- `done` and `busy` are never high in the same cycle.

## Test plan

Test plan uses WIDTH=8, DIGIT=2 (NDIG=4) unless stated otherwise.

- Reset for 2 cycles with `start`=1 held → `busy`=0, `done`=0, `sum`=0x00, `co`=0, `ovf`=0 throughout.
- a=0x03, b=0x01, cin=0, start pulsed at E0 → `busy` high for 4 cycles; `done` 1 cycle after E4; `sum`=0x04, `co`=0, `ovf`=0. Next: a=0x0F, b=0x21 → `sum`=0x30.
- a=0x4F, b=0xE1 → `sum`=0x30, `co`=1, `ovf`=0. Then a=0x7F, b=0x01 → `sum`=0x80, `co`=0, `ovf`=1. Then a=0xFF, b=0x00, cin=1 → `sum`=0x00, `co`=1, `ovf`=0 (carry ripples through all digits).
- Handshake:
  - Start a=0x10, b=0x20; pulse start at E2 with a=0xAA → ignored; result 0x30.
  - Hold start=1 through the DONE cycle with a=0x01, b=0x01 → second op accepted; `done` again 5 edges later with `sum`=0x02.
  - `sum` holds 0x30 during the second RUN.
- Assert reset at E2 of an a=0xFF, b=0x01 run → no `done`, outputs 0. A fresh start with a=0x05, b=0x06 gives `sum`=0x0B.
- Re-parametrise:
  - WIDTH=16, DIGIT=1: 0xFFFF+0x0001 → `sum`=0x0000, `co`=1, `done` 17 edges after accept.
  - WIDTH=8, DIGIT=8: 0x80+0x80 → `sum`=0x00, `co`=1, `ovf`=1, `done` 2 edges after accept.
